// File: rtl/cache_refill_arbiter.sv
// Shares one main-memory port between ICache line refills and DCache refills/writebacks.
// Define ARB_ROUND_ROBIN_EN to alternate priority on simultaneous requests; otherwise DCache always wins.
module cache_refill_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              CpuRst,
  input  logic              ICacheReq,
  input  logic [ADDR_W-1:0] ICacheAddr,
  input  logic              DCacheReq,
  input  logic              DCacheWe,
  input  logic [ADDR_W-1:0] DCacheAddr,
  input  logic [DATA_W-1:0] DCacheWrData,
  output logic              ICacheGnt,
  output logic              DCacheGnt,
  output logic [DATA_W-1:0] RdData,
  output logic              ICacheRdValid,
  output logic              DCacheRdValid,
  output logic              DCacheWrNext,
  output logic              ICacheDone,
  output logic              DCacheDone,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRdData
);

  localparam int CNT_W   = $clog2(LINE_WORDS);
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int LINE_SH = $clog2(LINE_WORDS * DATA_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_SH) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t            r_state;
  logic              r_owner_d;   // 1 = DCache owns the burst, 0 = ICache
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_pick_d;
  logic              w_burst;
  logic              w_busy;
  logic              w_beat;
  logic [ADDR_W-1:0] w_req_addr;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;
  // On a tie the cache that did not own the previous burst goes first.
  assign w_pick_d = DCacheReq & (~ICacheReq | ~r_last_d);
`else
  assign w_pick_d = DCacheReq;
`endif

  assign w_req_addr = w_pick_d ? DCacheAddr : ICacheAddr;

  always_ff @(posedge clk or posedge CpuRst) begin
    if (CpuRst) begin
      r_state   <= IDLE;
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_base    <= '0;
      r_cnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (ICacheReq || DCacheReq) begin
            r_state   <= BURST;
            r_owner_d <= w_pick_d;
            r_we      <= w_pick_d & DCacheWe;
            r_base    <= w_req_addr & LINE_MASK;
            r_cnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d  <= w_pick_d;
`endif
          end
        end
        BURST: begin
          if (MemAck) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_BEAT) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_burst = (r_state == BURST);
  assign w_busy  = (r_state != IDLE);
  assign w_beat  = w_burst & MemAck;

  assign ICacheGnt = w_busy & ~r_owner_d;
  assign DCacheGnt = w_busy &  r_owner_d;

  // Offset is confined to the counter bits, so the address never carries out of the line.
  assign MemReq    = w_burst;
  assign MemWe     = w_burst & r_we;
  assign MemAddr   = w_burst ? (r_base | (ADDR_W'(r_cnt) << BYTE_SH)) : '0;
  assign MemWrData = w_burst ? DCacheWrData : '0;

  assign RdData        = (w_beat & ~r_we) ? MemRdData : '0;
  assign ICacheRdValid = w_beat & ~r_we & ~r_owner_d;
  assign DCacheRdValid = w_beat & ~r_we &  r_owner_d;
  assign DCacheWrNext  = w_beat &  r_we;

  assign ICacheDone = (r_state == DONE) & ~r_owner_d;
  assign DCacheDone = (r_state == DONE) &  r_owner_d;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: expected beats/done pulses queued per stimulus, checked by a monitor.
module tb_cache_refill_arbiter;

  logic        clk = 1'b0;
  logic        CpuRst = 1'b0;
  logic        ICacheReq = 1'b0;
  logic [31:0] ICacheAddr = '0;
  logic        DCacheReq = 1'b0;
  logic        DCacheWe = 1'b0;
  logic [31:0] DCacheAddr = '0;
  logic [31:0] DCacheWrData = '0;
  logic        ICacheGnt, DCacheGnt;
  logic [31:0] RdData;
  logic        ICacheRdValid, DCacheRdValid, DCacheWrNext;
  logic        ICacheDone, DCacheDone;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWrData;
  logic        MemAck = 1'b0;
  logic [31:0] MemRdData;

  always #5 clk = ~clk;

  cache_refill_arbiter dut (
    .clk(clk), .CpuRst(CpuRst),
    .ICacheReq(ICacheReq), .ICacheAddr(ICacheAddr),
    .DCacheReq(DCacheReq), .DCacheWe(DCacheWe), .DCacheAddr(DCacheAddr), .DCacheWrData(DCacheWrData),
    .ICacheGnt(ICacheGnt), .DCacheGnt(DCacheGnt), .RdData(RdData),
    .ICacheRdValid(ICacheRdValid), .DCacheRdValid(DCacheRdValid), .DCacheWrNext(DCacheWrNext),
    .ICacheDone(ICacheDone), .DCacheDone(DCacheDone),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemAck(MemAck), .MemRdData(MemRdData)
  );

  // Memory returns 0xA0 + word index within the line.
  assign MemRdData = MemReq ? (32'hA0 + {28'b0, MemAddr[3:2]}) : 32'hDEAD_BEEF;

  logic [104:0] w_outs;
  assign w_outs = {ICacheGnt, DCacheGnt, RdData, ICacheRdValid, DCacheRdValid, DCacheWrNext,
                   ICacheDone, DCacheDone, MemReq, MemWe, MemAddr, MemWrData};

  typedef struct {
    logic [2:0]  kind;  // 1 IRdValid, 2 DRdValid, 3 DWrNext, 4 IDone, 5 DDone
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  bit  ack_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, i_done_n, d_done_n, i_done_at, d_done_at, wr_idx;
  bit drop_i, drop_d, wr_adv, auto_drop, ack_dflt;
  logic gi_log [0:63];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_burst(input logic [2:0] beat_kind, input logic [31:0] base,
                            input logic [31:0] dbase, input logic [2:0] done_kind);
    for (int i = 0; i < 4; i++) push_ev(beat_kind, base + 32'(4 * i), dbase + 32'(i));
    push_ev(done_kind, 32'h0, 32'h0);
  endtask

  task automatic reset_stats();
    cyc = 0; i_done_n = 0; d_done_n = 0; i_done_at = 0; d_done_at = 0;
    drop_i = 0; drop_d = 0; wr_adv = 0; wr_idx = 0;
  endtask

  // Called just after a rising edge; runs ncyc cycles, modelling the caches' side of the handshake.
  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      if (drop_i) begin ICacheReq = 1'b0; drop_i = 0; end
      if (drop_d) begin DCacheReq = 1'b0; drop_d = 0; end
      if (wr_adv) begin wr_idx++; wr_adv = 0; end
      DCacheWrData = 32'hD0 + 32'(wr_idx);
      MemAck = (ack_q.size() > 0) ? ack_q.pop_front() : ack_dflt;
      @(negedge clk);
      cyc++;
      if (cyc < 64) gi_log[cyc] = ICacheGnt;
      if (ICacheDone) begin i_done_n++; i_done_at = cyc; if (auto_drop) drop_i = 1; end
      if (DCacheDone) begin d_done_n++; d_done_at = cyc; if (auto_drop) drop_d = 1; end
      if (DCacheWrNext) wr_adv = 1;
      @(posedge clk); #1;
    end
  endtask

  int         nev;
  logic [2:0] kind;
  ev_t        got_e;

  always @(negedge clk) begin
    if (!CpuRst) begin
      nev = int'(ICacheRdValid) + int'(DCacheRdValid) + int'(DCacheWrNext)
          + int'(ICacheDone) + int'(DCacheDone);
      kind = ICacheRdValid ? 3'd1 : DCacheRdValid ? 3'd2 : DCacheWrNext ? 3'd3 :
             ICacheDone ? 3'd4 : DCacheDone ? 3'd5 : 3'd0;
      if (nev > 1) chk("one_event_per_cycle", 128'(nev), 128'd1);
      if (nev > 0) begin
        if (exp_q.size() == 0) chk("unexpected_event", 128'(kind), 128'd0);
        else begin
          got_e = exp_q.pop_front();
          chk("ev_kind", 128'(kind), 128'(got_e.kind));
          if (got_e.kind < 3'd4) begin
            chk("ev_addr", 128'(MemAddr), 128'(got_e.addr));
            chk("ev_data", 128'((kind == 3'd3) ? MemWrData : RdData), 128'(got_e.data));
          end
        end
      end
    end
  end

  initial begin
    auto_drop = 1; ack_dflt = 1;
    reset_stats();
    #1 CpuRst = 1'b1;
    #1 chk("reset_outputs", 128'(w_outs), 128'd0);
    repeat (2) @(posedge clk);
    #1;

    // ICache-only refill from 0x1234
    CpuRst = 1'b0;
    ICacheAddr = 32'h0000_1234; ICacheReq = 1'b1;
    reset_stats();
    push_burst(3'd1, 32'h1230, 32'hA0, 3'd4);
    run(7);
    chk("t1_idone_cycle", 128'(i_done_at), 128'd6);
    chk("t1_idone_count", 128'(i_done_n), 128'd1);
    for (int c = 1; c <= 7; c++)
      chk($sformatf("t1_igrant_c%0d", c), 128'(gi_log[c]), 128'((c >= 2 && c <= 6) ? 1 : 0));

    // Simultaneous requests held through reset exit: DCache first, then ICache
    CpuRst = 1'b1;
    ICacheAddr = 32'h0000_3004; ICacheReq = 1'b1;
    DCacheAddr = 32'h0000_2000; DCacheWe = 1'b0; DCacheReq = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    CpuRst = 1'b0;
    reset_stats();
    push_burst(3'd2, 32'h2000, 32'hA0, 3'd5);
    push_burst(3'd1, 32'h3000, 32'hA0, 3'd4);
    run(14);
    chk("t2_ddone_cycle", 128'(d_done_at), 128'd6);
    chk("t2_idone_cycle", 128'(i_done_at), 128'd12);
    chk("t2_ddone_count", 128'(d_done_n), 128'd1);
    chk("t2_idone_count", 128'(i_done_n), 128'd1);

    // Four back-to-back double requests
    auto_drop = 0;
    ICacheReq = 1'b1; DCacheReq = 1'b1;
    reset_stats();
`ifdef ARB_ROUND_ROBIN_EN
    push_burst(3'd2, 32'h2000, 32'hA0, 3'd5);
    push_burst(3'd1, 32'h3000, 32'hA0, 3'd4);
    push_burst(3'd2, 32'h2000, 32'hA0, 3'd5);
    push_burst(3'd1, 32'h3000, 32'hA0, 3'd4);
`else
    for (int b = 0; b < 4; b++) push_burst(3'd2, 32'h2000, 32'hA0, 3'd5);
`endif
    run(24);
    ICacheReq = 1'b0; DCacheReq = 1'b0;
    auto_drop = 1;
    run(2);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t3_ddone_count", 128'(d_done_n), 128'd2);
    chk("t3_idone_count", 128'(i_done_n), 128'd2);
    chk("t3_last_idone", 128'(i_done_at), 128'd24);
`else
    chk("t3_ddone_count", 128'(d_done_n), 128'd4);
    chk("t3_idone_count", 128'(i_done_n), 128'd0);
    chk("t3_last_ddone", 128'(d_done_at), 128'd24);
`endif

    // Writeback at 0x0FF8 with ack gaps; addresses stay inside the 0x0FF0 line
    reset_stats();
    ack_dflt = 0;
    ack_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    DCacheAddr = 32'h0000_0FF8; DCacheWe = 1'b1; DCacheReq = 1'b1;
    push_burst(3'd3, 32'h0FF0, 32'hD0, 3'd5);
    run(10);
    chk("t4_ddone_cycle", 128'(d_done_at), 128'd9);
    chk("t4_ddone_count", 128'(d_done_n), 128'd1);
    DCacheWe = 1'b0;
    ack_dflt = 1;

    // Reset after the second beat of a DCache refill
    reset_stats();
    DCacheAddr = 32'h0000_4000; DCacheReq = 1'b1;
    push_ev(3'd2, 32'h4000, 32'hA0);
    push_ev(3'd2, 32'h4004, 32'hA1);
    run(3);
    CpuRst = 1'b1;
    DCacheReq = 1'b0;
    #1 chk("t5_outputs_in_reset", 128'(w_outs), 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    CpuRst = 1'b0;
    ICacheAddr = 32'h0000_5008; ICacheReq = 1'b1;
    reset_stats();
    push_burst(3'd1, 32'h5000, 32'hA0, 3'd4);
    run(8);
    chk("t5_idone_cycle", 128'(i_done_at), 128'd6);
    chk("t5_no_ddone", 128'(d_done_n), 128'd0);

    // Owner drops its request after beat 1; then stray acks in IDLE
    reset_stats();
    DCacheAddr = 32'h0000_6000; DCacheReq = 1'b1;
    push_burst(3'd2, 32'h6000, 32'hA0, 3'd5);
    run(3);
    DCacheReq = 1'b0;
    run(5);
    chk("t6_ddone_cycle", 128'(d_done_at), 128'd6);
    chk("t6_ddone_count", 128'(d_done_n), 128'd1);
    run(3);
    MemAck = 1'b1;
    @(negedge clk);
    chk("t6_idle_ack_outputs", 128'(w_outs), 128'd0);
    @(posedge clk); #1;

    chk("expect_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_arbiter.md
CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 4, giving words per cache line; the value SHALL be a power of two, 2..16.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the byte address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the word width.
REQ-004 `clk  in  1`: the single clock; all state SHALL update on its rising edge.
REQ-005 `CpuRst  in  1`: asynchronous, active-high reset.
REQ-006 `ICacheReq  in  1`: ICache line-refill request, held until ICacheDone.
REQ-007 `ICacheAddr  in  ADDR_W`: ICache miss byte address.
REQ-008 `DCacheReq  in  1`: DCache line request, held until DCacheDone.
REQ-009 `DCacheWe  in  1`: DCache request type, 1=writeback and 0=refill; it SHALL be sampled at grant.
REQ-010 `DCacheAddr  in  ADDR_W`: DCache line byte address.
REQ-011 `DCacheWrData  in  DATA_W`: writeback word for the current beat.
REQ-012 `ICacheGnt, DCacheGnt  out  1`: owner indication for the whole burst.
REQ-013 `RdData  out  DATA_W`: refill word, shared by both caches.
REQ-014 `ICacheRdValid, DCacheRdValid  out  1`: refill word valid, one pulse per beat, sent to the owner only.
REQ-015 `DCacheWrNext  out  1`: writeback word accepted; the DCache advances to the next word.
REQ-016 `ICacheDone, DCacheDone  out  1`: burst-complete pulse, one cycle wide.
REQ-017 `MemReq  out  1`, `MemWe  out  1`, `MemAddr  out  ADDR_W`, `MemWrData  out  DATA_W`: single main-memory port.
REQ-018 `MemAck  in  1`, `MemRdData  in  DATA_W`: one word transfers in each cycle where MemReq and MemAck are both 1.

Function
REQ-019 The FSM SHALL have the states IDLE, BURST and DONE, and it SHALL reset to IDLE.
REQ-020 In IDLE, if any request is high, the block SHALL go to BURST on the next edge and latch the following:
- the owner;
- the type (MemWe);
- the base address, equal to the request address with its low log2(LINE_WORDS*DATA_W/8) bits cleared;
- the beat counter, set to 0.
REQ-021 Without ARB_ROUND_ROBIN_EN, when both requests are high in IDLE, DCache SHALL win.
REQ-022 The owner's Gnt SHALL be 1 in BURST and DONE, and both Gnt outputs SHALL be 0 in IDLE.
REQ-023 In BURST the block SHALL drive:
- MemReq = 1;
- MemAddr = base + counter*(DATA_W/8);
- MemWrData = DCacheWrData, combinationally.
REQ-024 On each accepted beat the counter SHALL increment, and the block SHALL pulse either the owner's RdValid with RdData = MemRdData in the same cycle, or DCacheWrNext for a writeback.
REQ-025 The address SHALL never carry beyond the line; the counter is log2(LINE_WORDS) bits and a beat accepted at LINE_WORDS-1 SHALL move the FSM to DONE.
REQ-026 DONE SHALL last exactly one cycle: the owner's Done pulse is high and MemReq is 0, and the next state is IDLE.
REQ-027 Requests SHALL NOT be sampled in BURST or DONE. There is therefore at least one IDLE cycle between bursts, with total latency = 1 + beats + stall cycles + 1.
REQ-028 If the owner's request drops mid-burst, the burst SHALL still complete, and Done SHALL still pulse.
REQ-029 MemAck outside BURST SHALL be ignored.
REQ-030 The non-owner's RdValid, WrNext and Done outputs SHALL stay 0 throughout any burst.

Reset
REQ-031 While CpuRst is 1, the following SHALL hold regardless of clk:
- the FSM is in IDLE;
- the counter, owner and base address are 0;
- every output is 0.
REQ-032 A reset mid-burst SHALL abandon the transfer immediately with no Done pulse. Arbitration SHALL restart from IDLE on the first edge after CpuRst falls.

Configuration
REQ-033 With ARB_ROUND_ROBIN_EN defined, a 1-bit last-owner register (reset value = ICache) SHALL give priority on a simultaneous request to the cache that did not own the previous burst. The register SHALL be updated at each grant.
REQ-034 Without ARB_ROUND_ROBIN_EN, the last-owner register SHALL NOT exist and priority is fixed to DCache.

Verification
REQ-035 ICache-only refill: ICacheReq=1, ICacheAddr=0x0000_1234, MemAck=1 every cycle, MemRdData=0xA0..0xA3 -> MemAddr 0x1230, 0x1234, 0x1238, 0x123C; four ICacheRdValid pulses; ICacheDone at cycle 6; ICacheGnt=1 in cycles 2-6.
REQ-036 Simultaneous requests at reset exit, fixed priority: both requests held -> DCache burst first, then one IDLE cycle, then the ICache burst; Done order is D, then I.
REQ-037 Same stimulus as REQ-036 with ARB_ROUND_ROBIN_EN defined and four back-to-back double requests -> owners D, I, D, I.
REQ-038 Writeback with gaps: DCacheWe=1, DCacheAddr=0x0000_0FF8, MemAck pattern 1,0,0,1,1,0,1 -> four DCacheWrNext pulses, and MemAddr wraps to within the 0x0FF0 line (0x0FF0..0x0FFC) with no carry into 0x1000.
REQ-039 Reset mid-burst: assert CpuRst after the 2nd beat -> all outputs 0 in the same cycle and no DCacheDone; a new ICacheReq after release -> normal burst starting at beat 0.
REQ-040 Request drop and stray ack: the owner drops its request after beat 1 -> the burst completes and Done pulses; MemAck=1 in IDLE -> no output change.
